// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for the sequential ALU.
// master drives requests, slave (the ALU) returns results.
interface alu_seq_if #(
    parameter int bits = 8
);
    logic            start;
    logic            ready;
    logic [bits-1:0] ALUA;
    logic [bits-1:0] ALUB;
    logic            ALUFlagIn;
    logic [3:0]      ALUControl;
    logic [bits-1:0] ALUResult;
    logic            C;
    logic            ALUFlags;
    logic            done;

    modport master (
        output start, ALUA, ALUB, ALUFlagIn, ALUControl,
        input  ready, ALUResult, C, ALUFlags, done
    );

    modport slave (
        input  start, ALUA, ALUB, ALUFlagIn, ALUControl,
        output ready, ALUResult, C, ALUFlags, done
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: one-cycle logic/arith ops, shifts one bit per clock.
// Define ALU_ROTATE_EN to add ROL (code A) and ROR (code B).
module alu_seq #(
    parameter int bits = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus
);
    localparam int CW = $clog2(bits + 1);
    localparam logic [bits:0]   BITS_W = (bits + 1)'(bits);
    localparam logic [CW-1:0]   N_MAX  = CW'(bits);
    localparam logic [CW-1:0]   CNT_1  = CW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [bits-1:0] work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic            fill_q, fill_d;
    logic [bits-1:0] res_q, res_d;
    logic            c_q, c_d;
    logic            z_q, z_d;

    logic [bits:0]   sum;
    logic [bits-1:0] one_r;
    logic            one_c;
    logic [CW-1:0]   n;
    logic [bits-1:0] step;
    logic            step_out;
    logic            in_bit;
    logic            left;
    logic            rot;

    function automatic logic is_shift(input logic [3:0] op);
`ifdef ALU_ROTATE_EN
        return (op == 4'h8) || (op == 4'h9) ||
               (op == 4'hA) || (op == 4'hB);
`else
        return (op == 4'h8) || (op == 4'h9);
`endif
    endfunction

    always_comb begin
        sum   = '0;
        one_r = '0;
        one_c = 1'b0;
        unique case (bus.ALUControl)
            4'h0: one_r = bus.ALUA & bus.ALUB;
            4'h1: one_r = bus.ALUA | bus.ALUB;
            4'h2: begin
                sum   = {1'b0, bus.ALUA} + {1'b0, bus.ALUB}
                      + {{bits{1'b0}}, bus.ALUFlagIn};
                one_r = sum[bits-1:0];
                one_c = sum[bits];
            end
            4'h3: begin
                sum   = {1'b0, bus.ALUA} + {{bits{1'b0}}, 1'b1};
                one_r = sum[bits-1:0];
                one_c = sum[bits];
            end
            4'h4: begin
                sum   = {1'b0, bus.ALUA} - {{bits{1'b0}}, 1'b1};
                one_r = sum[bits-1:0];
                one_c = sum[bits];
            end
            4'h5: one_r = ~bus.ALUA;
            4'h6: begin
                sum   = {1'b0, bus.ALUA} - {1'b0, bus.ALUB};
                one_r = sum[bits-1:0];
                one_c = sum[bits];
            end
            4'h7: one_r = bus.ALUA ^ bus.ALUB;
            default: ;
        endcase
    end

    assign n = ({1'b0, bus.ALUB} >= BITS_W) ? N_MAX : CW'(bus.ALUB);

    // Rotates feed the bit leaving one end back in at the other end.
    always_comb begin
        left = (op_q == 4'h8) || (op_q == 4'hA);
        rot  = (op_q == 4'hA) || (op_q == 4'hB);
        if (left) begin
            in_bit   = rot ? work_q[bits-1] : fill_q;
            step     = {work_q[bits-2:0], in_bit};
            step_out = work_q[bits-1];
        end else begin
            in_bit   = rot ? work_q[0] : fill_q;
            step     = {in_bit, work_q[bits-1:1]};
            step_out = work_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        res_d   = res_q;
        c_d     = c_q;
        z_d     = z_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.ALUControl;
                    fill_d  = bus.ALUFlagIn;
                    state_d = DONE;
                    if (is_shift(bus.ALUControl)) begin
                        if (n == '0) begin
                            res_d = bus.ALUA;
                            c_d   = 1'b0;
                            z_d   = (bus.ALUA == '0);
                        end else begin
                            work_d  = bus.ALUA;
                            cnt_d   = n;
                            state_d = SHIFT;
                        end
                    end else begin
                        res_d = one_r;
                        c_d   = one_c;
                        z_d   = (one_r == '0);
                    end
                end
            end
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - CNT_1;
                if (cnt_q == CNT_1) begin
                    res_d   = step;
                    c_d     = step_out;
                    z_d     = (step == '0);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            fill_q  <= 1'b0;
            res_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            res_q   <= res_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.ALUResult = res_q;
    assign bus.C         = c_q;
    assign bus.ALUFlags  = z_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (bits=8): expectations queued at accept,
// popped and compared when done pulses.
module tb_alu_seq;
    localparam int W = 8;

    typedef struct {
        string      tag;
        logic [7:0] r;
        logic       c;
        logic       z;
        int         lat;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    alu_seq_if #(.bits(W)) bus ();

    alu_seq #(.bits(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input string tag, input logic [3:0] op,
                                   input logic [7:0] a, input logic [7:0] b,
                                   input logic f);
        exp_t       e;
        int         n;
        logic [8:0]  s;
        logic [15:0] w;
        logic [7:0]  m;
        n = (b >= 8) ? 8 : int'(b);
        e.tag = tag;
        e.r = 8'h00;
        e.c = 1'b0;
        e.lat = 0;
        e.acc = 0;
        case (op)
            4'h0: e.r = a & b;
            4'h1: e.r = a | b;
            4'h2: begin s = a + b + f; e.r = s[7:0]; e.c = s[8]; end
            4'h3: begin s = a + 1; e.r = s[7:0]; e.c = s[8]; end
            4'h4: begin e.r = a - 8'd1; e.c = (a == 8'd0); end
            4'h5: e.r = ~a;
            4'h6: begin e.r = a - b; e.c = (a < b); end
            4'h7: e.r = a ^ b;
            4'h8: begin
                e.lat = n;
                if (n == 0) e.r = a;
                else begin
                    w = {8'h00, a} << n;
                    m = 8'hFF << n;
                    e.r = w[7:0] | (f ? ~m : 8'h00);
                    e.c = w[8];
                end
            end
            4'h9: begin
                e.lat = n;
                if (n == 0) e.r = a;
                else begin
                    w = {a, 8'h00} >> n;
                    m = 8'hFF >> n;
                    e.r = w[15:8] | (f ? ~m : 8'h00);
                    e.c = w[7];
                end
            end
`ifdef ALU_ROTATE_EN
            4'hA: begin
                e.lat = n;
                if (n == 0) e.r = a;
                else begin
                    w = {a, a} << n;
                    e.r = w[15:8];
                    e.c = e.r[0];
                end
            end
            4'hB: begin
                e.lat = n;
                if (n == 0) e.r = a;
                else begin
                    w = {a, a} >> n;
                    e.r = w[7:0];
                    e.c = e.r[7];
                end
            end
`endif
            default: ;
        endcase
        e.z = (e.r == 8'h00);
        return e;
    endfunction

    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic f);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        while (!bus.ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rdy_wait"}, 32'(k < 100), 32'd1);
        bus.ALUControl = op;
        bus.ALUA = a;
        bus.ALUB = b;
        bus.ALUFlagIn = f;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e = model(tag, op, a, b, f);
        e.acc = cyc;
        sb.push_back(e);
        check({tag, "_busy"}, 32'(bus.ready), 32'd0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || !bus.ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(k < 200), 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_res"}, 32'(bus.ALUResult), 32'(e.r));
                check({e.tag, "_c"}, 32'(bus.C), 32'(e.c));
                check({e.tag, "_z"}, 32'(bus.ALUFlags), 32'(e.z));
                check({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.ALUA = 8'h00;
        bus.ALUB = 8'h00;
        bus.ALUFlagIn = 1'b0;
        bus.ALUControl = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_res", 32'(bus.ALUResult), 32'd0);
        check("rst_c", 32'(bus.C), 32'd0);
        check("rst_z", 32'(bus.ALUFlags), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        issue("shl3", 4'h8, 8'hD6, 8'd3, 1'b1);
        issue("shr3", 4'h9, 8'hD6, 8'd3, 1'b1);
        issue("add_ff", 4'h2, 8'hFF, 8'h01, 1'b0);
        issue("sub", 4'h6, 8'h03, 8'h05, 1'b0);
        issue("shl200", 4'h8, 8'hD6, 8'd200, 1'b1);
        issue("shl0", 4'h8, 8'hD6, 8'd0, 1'b1);
        issue("shr8", 4'h9, 8'h81, 8'd8, 1'b0);
        issue("and", 4'h0, 8'hF0, 8'h3C, 1'b0);
        issue("or", 4'h1, 8'h50, 8'h0A, 1'b0);
        issue("addci", 4'h2, 8'h7E, 8'h01, 1'b1);
        issue("inc", 4'h3, 8'hFF, 8'h00, 1'b0);
        issue("dec0", 4'h4, 8'h00, 8'h00, 1'b0);
        issue("not", 4'h5, 8'hA5, 8'h00, 1'b0);
        issue("xor", 4'h7, 8'hAA, 8'hAA, 1'b0);
        issue("undef_c", 4'hC, 8'h12, 8'h34, 1'b1);
        issue("rol", 4'hA, 8'h81, 8'd1, 1'b0);
        issue("ror", 4'hB, 8'h81, 8'd9, 1'b0);
        wait_idle();

        issue("ign", 4'h8, 8'hD6, 8'd5, 1'b1);
        @(negedge clk);
        bus.ALUA = 8'h11;
        bus.ALUB = 8'h01;
        bus.ALUControl = 4'h0;
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        issue("abort", 4'h8, 8'hD6, 8'd5, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_res", 32'(bus.ALUResult), 32'd0);
        check("abort_c", 32'(bus.C), 32'd0);
        check("abort_z", 32'(bus.ALUFlags), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue("post_add", 4'h2, 8'h10, 8'h22, 1'b0);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            logic [7:0] a;
            logic [7:0] b;
            op = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = (op >= 4'h8) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            issue($sformatf("rnd%0d", i), op, a, b, 1'($urandom));
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
